approx_ha_mul_pipe: RTL
=======================

# approx_ha_mul_pipe

Parametrised, pipelined unsigned W×W multiplier with a configurable approximate half-adder compression stage. Partial-product rows are paired; each pair is compressed by a row of half adders. In the low APPROX_COLS columns, each half adder is replaced by an OR-sum cell with no carry when `approx_en` is set. The block adds valid/ready flow control, a per-result inexact flag and a saturating inexact-result counter, so it can be used in the multiplier exploration datapaths with runtime exact/approximate selection.

## Interface
- `W`, default 8: operand width; even, 4..16.
- `APPROX_COLS`, default 6: absolute product columns 0..APPROX_COLS-1 that use OR-sum cells when approximation is enabled; range 0..2W.
- `CNT_W`, default 16: width of the inexact-result counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand transfer request.
- `in_ready`  out  1  block can accept operands this cycle.
- `x`  in  W  unsigned multiplicand.
- `y`  in  W  unsigned multiplier.
- `approx_en`  in  1  per-transaction mode, sampled with the operands; 1 = approximate, 0 = exact.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `p`  out  2W  product, exact or approximate.
- `out_inexact`  out  1  `p` differs from the exact product.
- `cnt_clr`  in  1  synchronous clear of `inexact_cnt`.
- `inexact_cnt`  out  CNT_W  saturating count of delivered inexact results.

## Operation
- **Partial products:** row r (0..W-1) has bit j = `y[j] & x[r]` at weight r+j.
- **Pairing:** pair k (0..W/2-1) takes row 2k as the top row and row 2k+1 as the bottom row. Positions are relative to 2k.
  - Top bit t_j is at j = 0..W-1.
  - Bottom bit b_j = `y[j-1] & x[2k+1]` is at j = 1..W.
- **Compression at overlap positions j = 1..W-1:**
  - If `approx_en` = 1 and the absolute column 2k+j < APPROX_COLS: sum = t_j | b_j, carry = 0.
  - Otherwise: an exact half adder; sum = t_j ^ b_j, carry = t_j & b_j at j+1.
- **Non-overlap positions:** t_0 and b_W pass through unchanged.
- **Pair value:** `top + bottom` is formed as a (W+2)-bit number, then shifted left by 2k.
- **Final product:** `p` = sum of all shifted pair values, truncated to 2W bits. No overflow is possible.
- **Inexact flag:** `out_inexact` = OR over all OR-sum cells of (t_j & b_j). It is exactly 1 when the approximate `p` is below the exact product. It is always 0 when `approx_en` = 0 or APPROX_COLS = 0.
- **Pipeline:**
  - Stage S1 registers the pair sum/carry vectors, the inexact flag and a valid bit.
  - Stage S2 registers `p`, `out_inexact` and `out_valid`.
- **Flow control:**
  - `s2_adv = !out_valid || out_ready`
  - `s1_adv = !s1_valid || s2_adv`
  - `in_ready = s1_adv` (purely combinational from state and `out_ready`).
  - Input handshake: `in_valid & in_ready`. Output handshake: `out_valid & out_ready`.
- **Ordering:** results leave in acceptance order. No drops, no duplicates.
- **Counter:**
  - On an output handshake with `out_inexact` = 1, `inexact_cnt` increments, saturating at 2^CNT_W-1.
  - `cnt_clr` sets it to 0. If a clear and an increment fall in the same cycle, the clear wins and the result is 0.

## Timing
- **Reset values:** `s1_valid` = 0, `out_valid` = 0, `p` = 0, `out_inexact` = 0, `inexact_cnt` = 0. `in_ready` = 1 after reset.
- **Latency:** 2 cycles. Operands accepted at edge n appear with `out_valid` = 1 after edge n+1 (visible in cycle n+2) when there is no stall.
- **Throughput:** 1 result per cycle while `out_ready` = 1.
- **Stall:** while `out_valid` = 1 and `out_ready` = 0:
  - `p` and `out_inexact` stay stable.
  - S1 holds if valid; `in_ready` = 0 once S1 is full.
  - At most 2 transactions are in flight.
- **Simultaneous accept and deliver:** in a full pipe with `out_ready` = 1, a new input is accepted in the same cycle; there is no bubble.
- **Reset mid-operation:** `rst_n` low immediately clears all valids and the counter. In-flight transactions are discarded and `out_valid` drops asynchronously.
- **Per-transaction mode:** `approx_en` is captured per transaction. Mode changes between back-to-back inputs apply only to their own transaction.

## Test plan
- W=8, APPROX_COLS=6: x=3, y=3, `approx_en`=1 -> `p`=7, `out_inexact`=1. Same operands with `approx_en`=0 -> `p`=9, `out_inexact`=0.
- x=255, y=1, `approx_en`=1 -> `p`=255, `out_inexact`=0. x=255, y=255, `approx_en`=0 -> `p`=65025.
- Exhaustive 65536 vectors, `approx_en`=0 -> `p` equals x*y. With `approx_en`=1 -> `p` ≤ x*y, and `out_inexact` = (`p` != x*y).
- Stream 10 inputs, hold `out_ready`=0 for cycles 3..6 -> `in_ready` falls once 2 transactions are held; all 10 results arrive in order with no loss; first `out_valid` comes 2 cycles after the first accept.
- CNT_W=2: deliver 5 inexact results -> `inexact_cnt` saturates at 3. Assert `cnt_clr` together with an inexact handshake -> `inexact_cnt`=0.
- Pulse `rst_n` low with both stages full -> `out_valid`=0 immediately, `inexact_cnt`=0, `in_ready`=1 after release, and the next result is correct.

Source files
------------

// File: rtl/approx_ha_mul_pipe.sv
// Pipelined unsigned WxW multiplier: paired partial-product rows compressed by half adders,
// with the low APPROX_COLS columns swapped to carry-free OR cells when approx_en is set.
module approx_ha_mul_pipe #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 6,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     p,
    output logic               out_inexact,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   inexact_cnt
);

    localparam int PAIRS = W / 2;

    // Per pair: top row t_j = y[j] & x[2k], bottom row b_j = y[j-1] & x[2k+1].
    logic [PAIRS-1:0][W-1:0] w_top;
    logic [PAIRS-1:0][W-1:0] w_bot;
    logic [PAIRS-1:0][W:0]   w_sum;
    logic [PAIRS-1:0][W:0]   w_cry;
    logic                    w_inexact;
    logic [2*W-1:0]          w_prod;
    logic                    w_s1_adv;
    logic                    w_s2_adv;

    logic [PAIRS-1:0][W:0]   r_sum;
    logic [PAIRS-1:0][W:0]   r_cry;
    logic                    r_s1_inexact;
    logic                    r_s1_valid;
    logic                    r_out_valid;
    logic [2*W-1:0]          r_p;
    logic                    r_out_inexact;
    logic [CNT_W-1:0]        r_cnt;

    for (genvar k = 0; k < PAIRS; k++) begin : g_rows
        assign w_top[k] = y & {W{x[2*k]}};
        assign w_bot[k] = y & {W{x[2*k+1]}};
    end

    always_comb begin
        w_sum     = '0;
        w_cry     = '0;
        w_inexact = 1'b0;
        for (int k = 0; k < PAIRS; k++) begin
            w_sum[k][0] = w_top[k][0];
            w_sum[k][W] = w_bot[k][W-1];
            for (int j = 1; j < W; j++) begin
                if (approx_en && (2*k + j < APPROX_COLS)) begin
                    w_sum[k][j] = w_top[k][j] | w_bot[k][j-1];
                    w_inexact   = w_inexact | (w_top[k][j] & w_bot[k][j-1]);
                end else begin
                    w_sum[k][j]   = w_top[k][j] ^ w_bot[k][j-1];
                    w_cry[k][j+1] = w_top[k][j] & w_bot[k][j-1];
                end
            end
        end
    end

    // Each pair resolves to a (W+2)-bit value weighted by 2^(2k); the total never exceeds 2W bits.
    always_comb begin
        w_prod = '0;
        for (int k = 0; k < PAIRS; k++) begin
            w_prod = w_prod + (((2*W)'(r_sum[k]) + (2*W)'(r_cry[k])) << (2*k));
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a stage advances when it is empty or the stage after it is advancing.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_sum        <= '0;
            r_cry        <= '0;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_sum        <= w_sum;
                r_cry        <= w_cry;
                r_s1_inexact <= w_inexact;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_p           <= '0;
            r_out_inexact <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_p           <= w_prod;
                r_out_inexact <= r_s1_inexact;
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_inexact && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = w_s1_adv;
    assign out_valid   = r_out_valid;
    assign p           = r_p;
    assign out_inexact = r_out_inexact;
    assign inexact_cnt = r_cnt;

endmodule
